// File: rtl/usb_rx_pkg.sv
// Shared USB full-speed timing constants for the receive and transmit timers.
// Latency: n/a (constants and a width helper only).
// Backpressure: n/a.
package usb_rx_pkg;

  // System clocks per USB bit time.
  localparam int CLKS_PER_BIT = 8;
  // Phase count at which a bit is sampled (mid-bit).
  localparam int SAMPLE_PT    = 3;
  // Consecutive ones after which the next bit is a stuffed zero.
  localparam int MAX_ONES     = 6;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear/load and a programmable wrap value.
// Latency: count updates one clock after count_enable; rollover_flag is combinational.
// Backpressure: none; counts whenever count_enable is high.
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count,
  output logic             rollover_flag
);

  logic at_roll;

  assign at_roll = (count == rollover_val);

  // High in the cycle the counter is about to wrap back to zero.
  assign rollover_flag = count_enable && at_roll && !clear && !load;

  // Priority: clear, then load, then count with wrap at rollover_val.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count_enable) begin
      count <= at_roll ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/rx_bit_timer.sv
// USB FS receive bit timing: recovers the bit clock from D+ edges, strobes the NRZI decoder and drops stuffed zeros.
// Latency: shift_enable/shift_data/stuff_error combinational from registered phase; byte_received one cycle after the 8th data bit.
// Backpressure: none; the line rate cannot be stalled, so all strobes are free-running while enable_timer is high.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = usb_rx_pkg::CLKS_PER_BIT,
  parameter int SAMPLE_PT    = usb_rx_pkg::SAMPLE_PT,
  parameter int MAX_ONES     = usb_rx_pkg::MAX_ONES
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable_timer,
  input  logic d_edge,
  input  logic d_orig,
  output logic shift_enable,
  output logic shift_data,
  output logic byte_received,
  output logic stuff_error
);

  import usb_rx_pkg::*;

  localparam int PH_W   = cnt_width(CLKS_PER_BIT);
  localparam int ONES_W = $clog2(MAX_ONES + 1);

  logic [PH_W-1:0]   phase;
  logic              phase_wrap_unused;
  logic [2:0]        bit_idx_unused;
  logic              byte_done;
  logic [ONES_W-1:0] ones;
  logic              sample;
  logic              stuff_slot;
  logic              byte_q;

  // Bit-phase counter. A D+ edge marks phase 0 of a new bit, so the
  // counter is loaded with 1 for the following cycle.
  flex_counter #(
    .WIDTH (PH_W)
  ) u_phase_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (!enable_timer),
    .count_enable  (enable_timer),
    .load          (d_edge),
    .load_val      (PH_W'(1)),
    .rollover_val  (PH_W'(CLKS_PER_BIT - 1)),
    .count         (phase),
    .rollover_flag (phase_wrap_unused)
  );

  assign sample       = enable_timer && (phase == PH_W'(SAMPLE_PT));
  assign stuff_slot   = (ones == ONES_W'(MAX_ONES));
  assign shift_enable = sample;
  assign shift_data   = sample && !stuff_slot;
  assign stuff_error  = sample && stuff_slot && d_orig;

  // Bit-in-byte counter. Only real data bits advance it; the bit index
  // itself is not needed downstream, only its wrap.
  flex_counter #(
    .WIDTH (3)
  ) u_bit_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (!enable_timer),
    .count_enable  (shift_data),
    .load          (1'b0),
    .load_val      (3'd0),
    .rollover_val  (3'd7),
    .count         (bit_idx_unused),
    .rollover_flag (byte_done)
  );

  // Run length of decoded ones; the slot after MAX_ONES ones is always consumed as a stuff bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ones <= '0;
    end else if (!enable_timer) begin
      ones <= '0;
    end else if (sample) begin
      if (stuff_slot || !d_orig) begin
        ones <= '0;
      end else begin
        ones <= ones + ONES_W'(1);
      end
    end
  end

  // Delay byte completion one cycle so the shift register has captured bit 8.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      byte_q <= 1'b0;
    end else begin
      byte_q <= byte_done;
    end
  end

  // A packet abort in the same cycle swallows a pending byte pulse.
  assign byte_received = byte_q && enable_timer;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Self-checking bench for rx_bit_timer against a time-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rx_bit_timer;

  localparam int CPB = 8;
  localparam int SP  = 3;
  localparam int MO  = 6;

  logic clk = 1'b0;
  logic n_rst;
  logic enable_timer;
  logic d_edge;
  logic d_orig;
  logic shift_enable;
  logic shift_data;
  logic byte_received;
  logic stuff_error;

  int checks = 0;
  int fails  = 0;

  // Reference model: bit timing is "cycles since the last sync point mod CPB",
  // where a sync point is an edge cycle or the first enabled cycle.
  int t      = 0;
  int sync_t = 0;
  int run    = 0;
  int nbits  = 0;
  bit pend   = 1'b0;
  bit c_r, c_en, c_e, c_d;
  logic [3:0] exp_o;

  rx_bit_timer dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .enable_timer  (enable_timer),
    .d_edge        (d_edge),
    .d_orig        (d_orig),
    .shift_enable  (shift_enable),
    .shift_data    (shift_data),
    .byte_received (byte_received),
    .stuff_error   (stuff_error)
  );

  always #5 clk = ~clk;

  function automatic bit pred_se(input bit r, input bit en);
    return r && en && (((t - sync_t) % CPB) == SP);
  endfunction

  // Random bit that never lets a run of ones reach the stuff slot.
  function automatic bit safe_d();
    return (run >= MO - 1) ? 1'b0 : 1'($urandom);
  endfunction

  // Drive one cycle's inputs (called just after a falling edge) and form expectations.
  task automatic apply(input bit r, input bit en, input bit e, input bit d);
    bit se, slot;
    n_rst = r; enable_timer = en; d_edge = e; d_orig = d;
    c_r = r; c_en = en; c_e = e; c_d = d;
    se    = pred_se(r, en);
    slot  = (run == MO);
    exp_o = {se, se && !slot, pend && en && r, se && slot && d};
    #1;
  endtask

  // Clock the DUT and move the model to the next cycle.
  task automatic advance();
    @(posedge clk);
    if (!c_r || !c_en) begin
      sync_t = t + 1; run = 0; nbits = 0; pend = 1'b0;
    end else begin
      pend = 1'b0;
      if (exp_o[3]) begin
        if (run == MO) begin
          run = 0;
        end else begin
          run   = c_d ? run + 1 : 0;
          nbits = (nbits + 1) % 8;
          if (nbits == 0) pend = 1'b1;
        end
      end
      if (c_e) sync_t = t;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b0);
      advance();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if ({shift_enable, shift_data, byte_received, stuff_error} !== 4'b0000) begin
        fails++;
        $display("FAIL reset t=%0d outputs=%b required=0000", t, {shift_enable, shift_data, byte_received, stuff_error});
      end
      advance();
    end
    idle(2);
  endtask

  task automatic test_free_run();
    int t0, first_se, byte_t, nse, nsd;
    first_se = -1; byte_t = -1; nse = 0; nsd = 0;
    idle(1);
    t0 = t;
    for (int i = 0; i < 64; i++) begin
      apply(1'b1, 1'b1, 1'b0, safe_d());
      checks++;
      if ({shift_enable, shift_data, byte_received, stuff_error} !== exp_o) begin
        fails++;
        $display("FAIL free_run t=%0d out=%b exp=%b", t, {shift_enable, shift_data, byte_received, stuff_error}, exp_o);
      end
      if (shift_enable === 1'b1) begin
        nse++;
        if (first_se < 0) first_se = t - t0;
      end
      if (shift_data === 1'b1) nsd++;
      if (byte_received === 1'b1 && byte_t < 0) byte_t = t - t0;
      advance();
    end
    checks++;
    if (first_se != 3) begin fails++; $display("FAIL free_run_first_se got %0d exp 3", first_se); end
    checks++;
    if (nse != 8 || nsd != 8) begin fails++; $display("FAIL free_run_counts se=%0d sd=%0d exp 8/8", nse, nsd); end
    checks++;
    if (byte_t != 60) begin fails++; $display("FAIL free_run_byte got cycle %0d exp 60", byte_t); end
  endtask

  // Edge at phase 6, and a second edge coinciding with a sample.
  // The edge cycle counts as phase 0, so the next sample is SP cycles later.
  task automatic test_resync();
    int t0;
    int se_at[$];
    idle(1);
    t0 = t;
    for (int i = 0; i < 31; i++) begin
      apply(1'b1, 1'b1, (i == 6) || (i == 17), safe_d());
      checks++;
      if ({shift_enable, shift_data, byte_received, stuff_error} !== exp_o) begin
        fails++;
        $display("FAIL resync t=%0d out=%b exp=%b", t, {shift_enable, shift_data, byte_received, stuff_error}, exp_o);
      end
      if (shift_enable === 1'b1) se_at.push_back(t - t0);
      advance();
    end
    checks++;
    if (se_at.size() != 5 || se_at[0] != 3 || se_at[1] != 9 || se_at[2] != 17 || se_at[3] != 20 || se_at[4] != 28) begin
      fails++;
      $display("FAIL resync_times got %p exp '{3,9,17,20,28}", se_at);
    end
  endtask

  task automatic test_stuffed_zero();
    logic [6:0] pat;
    int idx, nse, nsd, nerr, post_sd;
    bit se, d;
    pat = 7'b0111111;
    idx = 0; nse = 0; nsd = 0; nerr = 0; post_sd = 0;
    idle(1);
    for (int c = 0; c < 200 && idx < 13; c++) begin
      se = pred_se(1'b1, 1'b1);
      d  = se ? ((idx < 7) ? pat[idx] : 1'b1) : 1'($urandom);
      apply(1'b1, 1'b1, 1'b0, d);
      checks++;
      if ({shift_enable, shift_data, byte_received, stuff_error} !== exp_o) begin
        fails++;
        $display("FAIL stuff_zero t=%0d out=%b exp=%b", t, {shift_enable, shift_data, byte_received, stuff_error}, exp_o);
      end
      if (se) begin
        if (idx < 7) begin
          nse += int'(shift_enable); nsd += int'(shift_data); nerr += int'(stuff_error);
        end else begin
          post_sd += int'(shift_data);
        end
        idx++;
      end
      advance();
    end
    checks++;
    if (idx != 13) begin fails++; $display("FAIL stuff_zero_timeout samples=%0d exp 13", idx); end
    checks++;
    if (nse != 7 || nsd != 6 || nerr != 0) begin
      fails++;
      $display("FAIL stuff_zero_counts se=%0d sd=%0d err=%0d exp 7/6/0", nse, nsd, nerr);
    end
    // A cleared run lets six further ones all pass as data.
    checks++;
    if (post_sd != 6) begin fails++; $display("FAIL stuff_zero_run_cleared sd=%0d exp 6", post_sd); end
  endtask

  task automatic test_stuff_error();
    int idx, nerr, err_idx, sd_at_err;
    bit se;
    idx = 0; nerr = 0; err_idx = -1; sd_at_err = -1;
    idle(1);
    for (int c = 0; c < 200 && idx < 7; c++) begin
      se = pred_se(1'b1, 1'b1);
      apply(1'b1, 1'b1, 1'b0, se ? 1'b1 : 1'($urandom));
      checks++;
      if ({shift_enable, shift_data, byte_received, stuff_error} !== exp_o) begin
        fails++;
        $display("FAIL stuff_err t=%0d out=%b exp=%b", t, {shift_enable, shift_data, byte_received, stuff_error}, exp_o);
      end
      if (stuff_error === 1'b1) begin
        nerr++; err_idx = idx; sd_at_err = int'(shift_data);
      end
      if (se) idx++;
      advance();
    end
    checks++;
    if (nerr != 1 || err_idx != 6 || sd_at_err != 0) begin
      fails++;
      $display("FAIL stuff_err_pulse count=%0d at_sample=%0d sd=%0d exp 1/6/0", nerr, err_idx, sd_at_err);
    end
  endtask

  // Byte ending in six ones, then a stuffed zero as the 9th sample.
  task automatic test_byte_then_stuff();
    logic [16:0] pat;
    int idx, tail;
    int br_at[$];
    bit se;
    pat = 17'b10101010_0_111111_00;
    idx = 0; tail = 0;
    idle(1);
    for (int c = 0; c < 400 && tail < 3; c++) begin
      se = pred_se(1'b1, 1'b1);
      apply(1'b1, 1'b1, 1'b0, se ? ((idx < 17) ? pat[idx] : 1'b0) : 1'($urandom));
      checks++;
      if ({shift_enable, shift_data, byte_received, stuff_error} !== exp_o) begin
        fails++;
        $display("FAIL byte_stuff t=%0d out=%b exp=%b", t, {shift_enable, shift_data, byte_received, stuff_error}, exp_o);
      end
      if (byte_received === 1'b1) br_at.push_back(idx);
      if (se) idx++;
      if (idx >= 17) tail++;
      advance();
    end
    checks++;
    if (br_at.size() != 2 || br_at[0] != 8 || br_at[1] != 17) begin
      fails++;
      $display("FAIL byte_stuff_pulses got %p exp '{8,17}", br_at);
    end
  endtask

  // Abort mid-byte by reset (use_rst=1) or by dropping enable_timer.
  task automatic test_abort(input bit use_rst);
    int idx, br_pre, br_post, br_idx;
    bit se;
    idx = 0; br_pre = 0; br_post = 0; br_idx = -1;
    idle(1);
    for (int c = 0; c < 200 && idx < 5; c++) begin
      se = pred_se(1'b1, 1'b1);
      apply(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({shift_enable, shift_data, byte_received, stuff_error} !== exp_o) begin
        fails++;
        $display("FAIL abort%0d_pre t=%0d out=%b exp=%b", use_rst, t, {shift_enable, shift_data, byte_received, stuff_error}, exp_o);
      end
      br_pre += int'(byte_received);
      if (se) idx++;
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      apply(!use_rst, use_rst, 1'($urandom), 1'($urandom));
      checks++;
      if ({shift_enable, shift_data, byte_received, stuff_error} !== 4'b0000) begin
        fails++;
        $display("FAIL abort%0d_hold t=%0d out=%b exp=0000", use_rst, t, {shift_enable, shift_data, byte_received, stuff_error});
      end
      advance();
    end
    idx = 0;
    for (int c = 0; c < 200 && idx < 10; c++) begin
      se = pred_se(1'b1, 1'b1);
      apply(1'b1, 1'b1, 1'b0, safe_d());
      checks++;
      if ({shift_enable, shift_data, byte_received, stuff_error} !== exp_o) begin
        fails++;
        $display("FAIL abort%0d_post t=%0d out=%b exp=%b", use_rst, t, {shift_enable, shift_data, byte_received, stuff_error}, exp_o);
      end
      if (byte_received === 1'b1) begin br_post++; br_idx = idx; end
      if (se) idx++;
      advance();
    end
    checks++;
    if (br_pre != 0 || br_post != 1 || br_idx != 8) begin
      fails++;
      $display("FAIL abort%0d_byte pre=%0d post=%0d at_sample=%0d exp 0/1/8", use_rst, br_pre, br_post, br_idx);
    end
  endtask

  task automatic test_random();
    int nerr = 0;
    for (int i = 0; i < 2000; i++) begin
      apply(($urandom % 300) != 0, ($urandom % 64) != 0, ($urandom % 10) == 0, ($urandom % 4) != 0);
      checks++;
      if ({shift_enable, shift_data, byte_received, stuff_error} !== exp_o) begin
        fails++;
        $display("FAIL random t=%0d out=%b exp=%b", t, {shift_enable, shift_data, byte_received, stuff_error}, exp_o);
      end
      nerr += int'(stuff_error === 1'b1);
      advance();
    end
    $display("random phase: %0d stuff errors observed", nerr);
  endtask

  initial begin
    n_rst = 1'b0; enable_timer = 1'b0; d_edge = 1'b0; d_orig = 1'b0;
    @(negedge clk);
    test_reset();
    test_free_run();
    test_resync();
    test_stuffed_zero();
    test_stuff_error();
    test_byte_then_stuff();
    test_abort(1'b1);
    test_abort(1'b0);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
